pc_stack: RTL and testbench
===========================

// Module: pc_stack
// PURPOSE
//  Parametrised program counter for the downsampling processor: increment, absolute/relative
//  branch, and CALL/RET with a hardware return-address stack. Drives the instruction-memory
//  address from control-unit strobes; replaces the fixed 8-bit increment/branch-only PC.
// PARAMETERS
//  ADDR_W      8   address width (bits); all PC arithmetic is modulo 2^ADDR_W
//  STACK_DEPTH 4   return-stack entries (>=1)
//  RESET_ADDR  0   value loaded into addr_out on reset
// PORTS
//  clk        in   1                      rising-edge clock
//  RST        in   1                      asynchronous, active-high reset
//  PCI        in   1                      increment: addr_out <= addr_out + 1
//  BRANCH     in   1                      jump; target chosen by REL
//  REL        in   1                      with BRANCH: 1 = relative (addr_in signed offset), 0 = absolute
//  CALL       in   1                      push addr_out+1, jump to addr_in (absolute)
//  RET        in   1                      pop top of stack into addr_out
//  addr_in    in   ADDR_W                 branch/call target or signed offset
//  addr_out   out  ADDR_W                 current PC (registered)
//  sp         out  $clog2(STACK_DEPTH+1)  number of valid stack entries
//  stk_full   out  1                      sp == STACK_DEPTH (combinational from sp)
//  stk_empty  out  1                      sp == 0 (combinational from sp)
//  err        out  1                      sticky: overflow/underflow occurred
// BEHAVIOUR
//  - RST high (async): addr_out=RESET_ADDR, sp=0, err=0, stack contents don't-care; holds while high.
//    RST mid-operation discards any pending command; first update is the first posedge after release.
//  - All updates on posedge clk; addr_out reflects a command one cycle after it is sampled.
//  - Priority when several strobes are high: RET > CALL > BRANCH > PCI. Lower ones ignored that cycle.
//  - No strobe: addr_out, sp, err hold.
//  - PCI: addr_out+1; ADDR_W'(2^ADDR_W-1) wraps to 0.
//  - BRANCH, REL=0: addr_out <= addr_in.
//  - BRANCH, REL=1: addr_out <= addr_out + sign-extended addr_in, truncated to ADDR_W (wraps both ways).
//  - CALL, !stk_full: stack[sp] <= addr_out+1 (wrapped), sp <= sp+1, addr_out <= addr_in.
//  - CALL, stk_full: overflow -> addr_out, sp, stack unchanged; err <= 1.
//  - RET, !stk_empty: addr_out <= stack[sp-1], sp <= sp-1.
//  - RET, stk_empty: underflow -> addr_out, sp unchanged; err <= 1.
//  - err clears only on RST. Stack is LIFO; entries above sp are never read.
//  - No combinational path from any input to addr_out or sp.
// TESTING (ADDR_W=8, STACK_DEPTH=4, RESET_ADDR=0)
//  1. Reset then PCI for 3 cycles -> addr_out 0,1,2,3; PCI at 8'hFF -> 8'h00; sp=0, err=0.
//  2. addr_out=8'h10: BRANCH REL=0 addr_in=12 -> 12; BRANCH REL=1 addr_in=8'hFC (-4) -> 8;
//     at 8'hFE, REL=1 addr_in=5 -> 8'h03.
//  3. At 8'h05 CALL addr_in=8'h40 -> addr_out=8'h40, sp=1; PCI x2 -> 8'h42; RET -> 8'h06, sp=0.
//  4. Nested: CALL to 8'h20,8'h30,8'h40,8'h50 -> sp=4, stk_full; 5th CALL to 8'h60 -> addr_out
//     stays 8'h50, err=1; four RETs return 8'h41,8'h31,8'h21,original+1; RET on empty -> hold, err stays 1.
//  5. Simultaneous at sp=1: RET+CALL+PCI high -> pop taken only (sp=0); BRANCH+PCI -> branch target.
//  6. RST asserted between clock edges with sp=3, err=1 -> immediately addr_out=0, sp=0, err=0;
//     RET after release -> underflow, err=1.

Source files
------------

// File: rtl/pc_stack.sv
// pc_stack: program counter with increment, absolute/relative branch, and CALL/RET return-address stack.
module pc_stack #(
    parameter int ADDR_W = 8,
    parameter int STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
    localparam int SP_W = $clog2(STACK_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              PCI,
    input  logic              BRANCH,
    input  logic              REL,
    input  logic              CALL,
    input  logic              RET,
    input  logic [ADDR_W-1:0] addr_in,
    output logic [ADDR_W-1:0] addr_out,
    output logic [SP_W-1:0]   sp,
    output logic              stk_full,
    output logic              stk_empty,
    output logic              err
);
    localparam int IDX_W = STACK_DEPTH > 1 ? $clog2(STACK_DEPTH) : 1;
    logic [ADDR_W-1:0] r_pc, r_stack [STACK_DEPTH];
    logic [SP_W-1:0]   r_sp;
    logic              r_err;
    logic [ADDR_W-1:0] w_pc_nxt, w_pc_inc;
    logic [SP_W-1:0]   w_sp_nxt;
    logic              w_err_nxt, w_full, w_empty, w_push;
    logic [IDX_W-1:0]  w_wr_idx, w_rd_idx;
    assign w_full    = r_sp == SP_W'(STACK_DEPTH);
    assign w_empty   = r_sp == '0;
    assign w_pc_inc  = r_pc + ADDR_W'(1);
    assign w_wr_idx  = IDX_W'(r_sp);
    assign w_rd_idx  = IDX_W'(r_sp - SP_W'(1));
    assign w_push    = CALL && !RET && !w_full;
    // Adding the raw offset is equivalent to sign-extending it to ADDR_W, modulo 2^ADDR_W.
    always_comb begin
        w_pc_nxt  = r_pc;
        w_sp_nxt  = r_sp;
        w_err_nxt = r_err;
        if (RET) begin
            if (w_empty) w_err_nxt = 1'b1;
            else begin
                w_pc_nxt = r_stack[w_rd_idx];
                w_sp_nxt = r_sp - SP_W'(1);
            end
        end else if (CALL) begin
            if (w_full) w_err_nxt = 1'b1;
            else begin
                w_pc_nxt = addr_in;
                w_sp_nxt = r_sp + SP_W'(1);
            end
        end else if (BRANCH) w_pc_nxt = REL ? r_pc + addr_in : addr_in;
        else if (PCI) w_pc_nxt = w_pc_inc;
    end
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_pc  <= RESET_ADDR;
            r_sp  <= '0;
            r_err <= 1'b0;
        end else begin
            r_pc  <= w_pc_nxt;
            r_sp  <= w_sp_nxt;
            r_err <= w_err_nxt;
        end
    end
    always_ff @(posedge clk) begin
        if (w_push) r_stack[w_wr_idx] <= w_pc_inc;
    end
    assign addr_out  = r_pc;
    assign sp        = r_sp;
    assign stk_full  = w_full;
    assign stk_empty = w_empty;
    assign err       = r_err;
endmodule

// File: tb/tb_pc_stack.sv
// tb_pc_stack: directed vectors for pc_stack (ADDR_W=8, STACK_DEPTH=4, RESET_ADDR=0).
module tb_pc_stack;
    logic       clk = 1'b0, rst = 1'b1;
    logic       pci = 0, branch = 0, rel = 0, call = 0, ret = 0;
    logic [7:0] addr_in = '0, addr_out;
    logic [2:0] sp;
    logic       stk_full, stk_empty, err;
    int         n_vec = 0, n_err = 0;

    pc_stack dut (
        .clk(clk), .RST(rst), .PCI(pci), .BRANCH(branch), .REL(rel), .CALL(call), .RET(ret),
        .addr_in(addr_in), .addr_out(addr_out), .sp(sp), .stk_full(stk_full),
        .stk_empty(stk_empty), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cmd(input logic r, input logic c, input logic b, input logic rl,
                       input logic p, input logic [7:0] a);
        ret = r; call = c; branch = b; rel = rl; pci = p; addr_in = a;
        @(posedge clk);
        #1;
        ret = 0; call = 0; branch = 0; rel = 0; pci = 0; addr_in = '0;
    endtask

    initial begin
        #12;
        check("rst_addr", addr_out, 8'h00);
        check("rst_sp", sp, 0);
        check("rst_err", err, 0);
        check("rst_empty", stk_empty, 1);
        check("rst_full", stk_full, 0);
        rst = 0;
        // 1. increment and wrap
        for (int i = 1; i <= 3; i++) begin
            cmd(0, 0, 0, 0, 1, 8'h00);
            check("pci", addr_out, i);
        end
        cmd(0, 0, 1, 0, 0, 8'hFF);
        check("br_ff", addr_out, 8'hFF);
        cmd(0, 0, 0, 0, 1, 8'h00);
        check("pci_wrap", addr_out, 8'h00);
        check("pci_sp", sp, 0);
        check("pci_err", err, 0);
        cmd(0, 0, 0, 0, 0, 8'h55);
        check("idle_hold", addr_out, 8'h00);
        // 2. branches
        cmd(0, 0, 1, 0, 0, 8'h10);
        check("br_abs10", addr_out, 8'h10);
        cmd(0, 0, 1, 0, 0, 8'd12);
        check("br_abs12", addr_out, 8'd12);
        cmd(0, 0, 1, 1, 0, 8'hFC);
        check("br_rel_neg", addr_out, 8'd8);
        cmd(0, 0, 1, 0, 0, 8'hFE);
        cmd(0, 0, 1, 1, 0, 8'h05);
        check("br_rel_wrap", addr_out, 8'h03);
        // 3. single call/return
        cmd(0, 0, 1, 0, 0, 8'h05);
        cmd(0, 1, 0, 0, 0, 8'h40);
        check("call_addr", addr_out, 8'h40);
        check("call_sp", sp, 1);
        cmd(0, 0, 0, 0, 1, 8'h00);
        cmd(0, 0, 0, 0, 1, 8'h00);
        check("sub_pci", addr_out, 8'h42);
        cmd(1, 0, 0, 0, 0, 8'h00);
        check("ret_addr", addr_out, 8'h06);
        check("ret_sp", sp, 0);
        // 4. nested to full, overflow, unwind, underflow
        cmd(0, 0, 1, 0, 0, 8'h10);
        cmd(0, 1, 0, 0, 0, 8'h20);
        cmd(0, 1, 0, 0, 0, 8'h30);
        cmd(0, 1, 0, 0, 0, 8'h40);
        cmd(0, 1, 0, 0, 0, 8'h50);
        check("nest_addr", addr_out, 8'h50);
        check("nest_sp", sp, 4);
        check("nest_full", stk_full, 1);
        check("nest_err0", err, 0);
        cmd(0, 1, 0, 0, 0, 8'h60);
        check("ovf_addr", addr_out, 8'h50);
        check("ovf_sp", sp, 4);
        check("ovf_err", err, 1);
        cmd(1, 0, 0, 0, 0, 8'h00);
        check("unw1", addr_out, 8'h41);
        cmd(1, 0, 0, 0, 0, 8'h00);
        check("unw2", addr_out, 8'h31);
        cmd(1, 0, 0, 0, 0, 8'h00);
        check("unw3", addr_out, 8'h21);
        cmd(1, 0, 0, 0, 0, 8'h00);
        check("unw4", addr_out, 8'h11);
        check("unw_empty", stk_empty, 1);
        cmd(1, 0, 0, 0, 0, 8'h00);
        check("udf_addr", addr_out, 8'h11);
        check("udf_sp", sp, 0);
        check("udf_err", err, 1);
        // 5. priority
        cmd(0, 1, 0, 0, 0, 8'h70);
        check("pri_call", addr_out, 8'h70);
        cmd(1, 1, 0, 0, 1, 8'h80);
        check("pri_ret_addr", addr_out, 8'h12);
        check("pri_ret_sp", sp, 0);
        cmd(0, 0, 1, 0, 1, 8'h33);
        check("pri_branch", addr_out, 8'h33);
        // 6. async reset mid-cycle
        cmd(0, 1, 0, 0, 0, 8'h20);
        cmd(0, 1, 0, 0, 0, 8'h30);
        cmd(0, 1, 0, 0, 0, 8'h40);
        check("pre_rst_sp", sp, 3);
        #2;
        rst = 1;
        pci = 1;
        #1;
        check("async_addr", addr_out, 8'h00);
        check("async_sp", sp, 0);
        check("async_err", err, 0);
        @(posedge clk);
        #1;
        check("rst_hold", addr_out, 8'h00);
        pci = 0;
        rst = 0;
        cmd(1, 0, 0, 0, 0, 8'h00);
        check("post_udf_addr", addr_out, 8'h00);
        check("post_udf_sp", sp, 0);
        check("post_udf_err", err, 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
